// File: rtl/ru_sched_pkg.sv
// ---------------------------------------------------------------------------
// ru_sched_pkg
// Shared types and constants for the multipass recompute scheduler.
//   sched_state_e  : scheduler FSM states
//   DEF_*          : default array / RU configuration (4x4, INNER=4, 2 RUs)
//   IDX_W          : width of a PE count for the default array (0..ROWS*COLS)
//   ROW_W, COL_W   : row / column index widths for the default array
//   max3()         : largest of three ints, used to size the shared counter
// ---------------------------------------------------------------------------
package ru_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_WB     = 3'd5,
    ST_DONE   = 3'd6
  } sched_state_e;

  localparam int DEF_ROWS         = 4;
  localparam int DEF_COLS         = 4;
  localparam int DEF_INNER        = 4;
  localparam int DEF_WORD_SIZE    = 16;
  localparam int DEF_NUM_RU       = 2;
  localparam int DEF_DRAIN_CYCLES = 2;

  localparam int IDX_W = $clog2(DEF_ROWS * DEF_COLS + 1);
  localparam int ROW_W = $clog2(DEF_ROWS);
  localparam int COL_W = $clog2(DEF_COLS);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    else m = m;
    if (c > m) m = c;
    else m = m;
    return m;
  endfunction

endpackage

// File: rtl/ru_operand_mux.sv
// ---------------------------------------------------------------------------
// ru_operand_mux
// Operand selector for one recompute unit. For the PE (row_i, col_i) and the
// current inner index k_i it picks top(k, col) and left(row, k) out of the
// flattened operand matrices. Both operands are forced to zero when en_i=0.
//   en_i          : slot is filled and streaming
//   k_i           : inner index
//   row_i, col_i  : PE assigned to this RU
//   top_matrix_i  : elem(k,c) at [(k*COLS+c)*WORD_SIZE +: WORD_SIZE]
//   left_matrix_i : elem(r,k) at [(r*INNER+k)*WORD_SIZE +: WORD_SIZE]
//   top_o, left_o : selected operands
// ---------------------------------------------------------------------------
module ru_operand_mux import ru_sched_pkg::*; #(
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter int INNER     = DEF_INNER,
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int K_W       = (INNER > 1) ? $clog2(INNER) : 1
) (
  input  logic                              en_i,
  input  logic [K_W-1:0]                    k_i,
  input  logic [$clog2(ROWS)-1:0]           row_i,
  input  logic [$clog2(COLS)-1:0]           col_i,
  input  logic [INNER*COLS*WORD_SIZE-1:0]   top_matrix_i,
  input  logic [ROWS*INNER*WORD_SIZE-1:0]   left_matrix_i,
  output logic [WORD_SIZE-1:0]              top_o,
  output logic [WORD_SIZE-1:0]              left_o
);

  // Element select; disabled slots see zero operands.
  always_comb begin
    top_o  = '0;
    left_o = '0;
    if (en_i) begin
      top_o  = top_matrix_i[(int'(k_i) * COLS + int'(col_i)) * WORD_SIZE +: WORD_SIZE];
      left_o = left_matrix_i[(int'(row_i) * INNER + int'(k_i)) * WORD_SIZE +: WORD_SIZE];
    end else begin
      top_o  = '0;
      left_o = '0;
    end
  end

endmodule

// File: rtl/ru_multipass_scheduler.sv
// ---------------------------------------------------------------------------
// ru_multipass_scheduler
// Schedules recompute of faulty PEs (fault_map bit = 0) onto NUM_RU recompute
// units, in as many passes as needed. Each pass: SCAN picks up to NUM_RU
// pending PEs, LOAD clears their RUs, STREAM feeds INNER operand pairs, DRAIN
// waits out the RU pipeline, WB writes one result per filled slot. PEs that
// turn faulty mid-run trigger one extra rescan from index 0.
// Ports:
//   clk, rst (async, active-high), start (pulse, ignored while busy)
//   fault_map, top_matrix, left_matrix, ru_result      : inputs
//   ru_en, ru_clear, ru_top_inputs, ru_left_inputs      : RU drive
//   ru_row_mapping, ru_col_mapping                      : PE held by each RU
//   res_valid, res_row, res_col, res_data               : result write-back
//   busy, done, fault_count                             : run status
// ---------------------------------------------------------------------------
module ru_multipass_scheduler import ru_sched_pkg::*; #(
  parameter int ROWS         = DEF_ROWS,
  parameter int COLS         = DEF_COLS,
  parameter int INNER        = DEF_INNER,
  parameter int WORD_SIZE    = DEF_WORD_SIZE,
  parameter int NUM_RU       = DEF_NUM_RU,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [ROWS*COLS-1:0]                fault_map,
  input  logic [INNER*COLS*WORD_SIZE-1:0]     top_matrix,
  input  logic [ROWS*INNER*WORD_SIZE-1:0]     left_matrix,
  input  logic [NUM_RU*WORD_SIZE-1:0]         ru_result,
  output logic [NUM_RU-1:0]                   ru_en,
  output logic [NUM_RU-1:0]                   ru_clear,
  output logic [NUM_RU*WORD_SIZE-1:0]         ru_top_inputs,
  output logic [NUM_RU*WORD_SIZE-1:0]         ru_left_inputs,
  output logic [NUM_RU*$clog2(ROWS)-1:0]      ru_row_mapping,
  output logic [NUM_RU*$clog2(COLS)-1:0]      ru_col_mapping,
  output logic                                res_valid,
  output logic [$clog2(ROWS)-1:0]             res_row,
  output logic [$clog2(COLS)-1:0]             res_col,
  output logic [WORD_SIZE-1:0]                res_data,
  output logic                                busy,
  output logic                                done,
  output logic [$clog2(ROWS*COLS+1)-1:0]      fault_count
);

  localparam int NPE     = ROWS * COLS;
  localparam int RW      = $clog2(ROWS);
  localparam int CW      = $clog2(COLS);
  localparam int PW      = $clog2(NPE);          // PE index
  localparam int IW      = $clog2(NPE + 1);      // PE index plus "past the end"
  localparam int SW      = $clog2(NUM_RU + 1);   // filled-slot count
  localparam int KW      = (INNER > 1) ? $clog2(INNER) : 1;
  localparam int CNT_W   = $clog2(max3(INNER, DRAIN_CYCLES, NUM_RU) + 1);

  sched_state_e                   state_q, state_d;
  logic [IW-1:0]                  scan_ptr_q, scan_ptr_d;
  logic [NPE-1:0]                 pend_q, pend_d;
  logic [NPE-1:0]                 done_mask_q, done_mask_d;
  logic                           rescan_q, rescan_d;
  logic [SW-1:0]                  nfill_q, nfill_d;
  logic [NUM_RU-1:0][PW-1:0]      slot_idx_q, slot_idx_d;
  logic [NUM_RU-1:0][RW-1:0]      row_map_q, row_map_d;
  logic [NUM_RU-1:0][CW-1:0]      col_map_q, col_map_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;   // k in STREAM, drain count, WB slot
  logic [IW-1:0]                  fcount_q, fcount_d;

  logic [PW-1:0]                  cur_idx_s;
  logic                           scan_hit_s;
  logic [SW-1:0]                  fill_next_s;
  logic                           run_s;

  // State and bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      scan_ptr_q  <= '0;
      pend_q      <= '0;
      done_mask_q <= '0;
      rescan_q    <= 1'b0;
      nfill_q     <= '0;
      slot_idx_q  <= '0;
      row_map_q   <= '0;
      col_map_q   <= '0;
      cnt_q       <= '0;
      fcount_q    <= '0;
    end else begin
      state_q     <= state_d;
      scan_ptr_q  <= scan_ptr_d;
      pend_q      <= pend_d;
      done_mask_q <= done_mask_d;
      rescan_q    <= rescan_d;
      nfill_q     <= nfill_d;
      slot_idx_q  <= slot_idx_d;
      row_map_q   <= row_map_d;
      col_map_q   <= col_map_d;
      cnt_q       <= cnt_d;
      fcount_q    <= fcount_d;
    end
  end

  // Next-state logic for the FSM, scan pointer, slot table and masks.
  always_comb begin
    state_d     = state_q;
    scan_ptr_d  = scan_ptr_q;
    pend_d      = pend_q;
    done_mask_d = done_mask_q;
    rescan_d    = rescan_q;
    nfill_d     = nfill_q;
    slot_idx_d  = slot_idx_q;
    row_map_d   = row_map_q;
    col_map_d   = col_map_q;
    cnt_d       = cnt_q;
    fcount_d    = fcount_q;
    cur_idx_s   = scan_ptr_q[PW-1:0];
    scan_hit_s  = 1'b0;
    fill_next_s = nfill_q;
    run_s       = (state_q != ST_IDLE) && (state_q != ST_DONE);

    // A PE faulty now but absent from the snapshot needs a later rescan.
    if (run_s && ((~fault_map & ~pend_q) != '0)) rescan_d = 1'b1;
    else rescan_d = rescan_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pend_d      = ~fault_map;
          done_mask_d = '0;
          fcount_d    = '0;
          scan_ptr_d  = '0;
          rescan_d    = 1'b0;
          nfill_d     = '0;
          state_d     = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        scan_hit_s = pend_q[cur_idx_s] && !done_mask_q[cur_idx_s];
        for (int i = 0; i < NUM_RU; i++) begin
          if (scan_hit_s && (nfill_q == SW'(i))) slot_idx_d[i] = cur_idx_s;
          else slot_idx_d[i] = slot_idx_q[i];
        end
        fill_next_s = nfill_q + SW'(scan_hit_s);
        nfill_d     = fill_next_s;
        scan_ptr_d  = scan_ptr_q + IW'(1);
        if ((fill_next_s == SW'(NUM_RU)) || (cur_idx_s == PW'(NPE - 1))) begin
          if (fill_next_s == '0) state_d = ST_DONE;
          else state_d = ST_LOAD;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_LOAD: begin
        for (int i = 0; i < NUM_RU; i++) begin
          if (SW'(i) < nfill_q) begin
            row_map_d[i] = RW'(slot_idx_q[i] / COLS);
            col_map_d[i] = CW'(slot_idx_q[i] % COLS);
          end else begin
            row_map_d[i] = '0;
            col_map_d[i] = '0;
          end
        end
        cnt_d   = '0;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (cnt_q == CNT_W'(INNER - 1)) begin
          cnt_d   = '0;
          state_d = (DRAIN_CYCLES == 0) ? ST_WB : ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_WB;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WB: begin
        for (int i = 0; i < NUM_RU; i++) begin
          if (cnt_q == CNT_W'(i)) done_mask_d[slot_idx_q[i]] = 1'b1;
          else done_mask_d[slot_idx_q[i]] = done_mask_d[slot_idx_q[i]];
        end
        fcount_d = fcount_q + IW'(1);
        if ((cnt_q + CNT_W'(1)) == CNT_W'(nfill_q)) begin
          cnt_d   = '0;
          nfill_d = '0;
          if (scan_ptr_q < IW'(NPE)) begin
            state_d = ST_SCAN;
          end else if (rescan_q) begin
            // Fresh snapshot already covers every current fault, so the
            // detector's request from this same cycle is dropped.
            rescan_d   = 1'b0;
            scan_ptr_d = '0;
            pend_d     = ~fault_map;
            state_d    = ST_SCAN;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode; res_* stay zero outside WB.
  always_comb begin
    busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done           = 1'b0;
    ru_en          = '0;
    ru_clear       = '0;
    res_valid      = 1'b0;
    res_row        = '0;
    res_col        = '0;
    res_data       = '0;
    ru_row_mapping = row_map_q;
    ru_col_mapping = col_map_q;
    fault_count    = fcount_q;
    case (state_q)
      ST_LOAD: begin
        for (int i = 0; i < NUM_RU; i++) ru_clear[i] = (SW'(i) < nfill_q);
      end
      ST_STREAM: begin
        for (int i = 0; i < NUM_RU; i++) ru_en[i] = (SW'(i) < nfill_q);
      end
      ST_WB: begin
        res_valid = 1'b1;
        for (int i = 0; i < NUM_RU; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            res_row  = row_map_q[i];
            res_col  = col_map_q[i];
            res_data = ru_result[i*WORD_SIZE +: WORD_SIZE];
          end else begin
            res_row  = res_row;
            res_col  = res_col;
            res_data = res_data;
          end
        end
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

  for (genvar g = 0; g < NUM_RU; g++) begin : g_mux
    ru_operand_mux #(
      .ROWS      (ROWS),
      .COLS      (COLS),
      .INNER     (INNER),
      .WORD_SIZE (WORD_SIZE),
      .K_W       (KW)
    ) u_mux (
      .en_i          (ru_en[g]),
      .k_i           (cnt_q[KW-1:0]),
      .row_i         (row_map_q[g]),
      .col_i         (col_map_q[g]),
      .top_matrix_i  (top_matrix),
      .left_matrix_i (left_matrix),
      .top_o         (ru_top_inputs[g*WORD_SIZE +: WORD_SIZE]),
      .left_o        (ru_left_inputs[g*WORD_SIZE +: WORD_SIZE])
    );
  end

endmodule

// File: tb/tb_ru_multipass_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ru_multipass_scheduler
// Directed bench for the 4x4 / INNER=4 / 2-RU configuration. A small RU
// accumulator model sits on the RU ports; left is all ones and
// top(k,c)=c+1, so every recomputed C(r,c) is 4*(c+1).
// ---------------------------------------------------------------------------
module tb_ru_multipass_scheduler;
  import ru_sched_pkg::*;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int INNER = 4;
  localparam int WS    = 16;
  localparam int NRU   = 2;
  localparam int DRAIN = 2;

  typedef struct packed {
    logic [ROW_W-1:0] r;
    logic [COL_W-1:0] c;
    logic [WS-1:0]    d;
  } res_t;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         start;
  logic [ROWS*COLS-1:0]         fault_map;
  logic [INNER*COLS*WS-1:0]     top_matrix;
  logic [ROWS*INNER*WS-1:0]     left_matrix;
  logic [NRU*WS-1:0]            ru_result;
  logic [NRU-1:0]               ru_en;
  logic [NRU-1:0]               ru_clear;
  logic [NRU*WS-1:0]            ru_top_inputs;
  logic [NRU*WS-1:0]            ru_left_inputs;
  logic [NRU*ROW_W-1:0]         ru_row_mapping;
  logic [NRU*COL_W-1:0]         ru_col_mapping;
  logic                         res_valid;
  logic [ROW_W-1:0]             res_row;
  logic [COL_W-1:0]             res_col;
  logic [WS-1:0]                res_data;
  logic                         busy;
  logic                         done;
  logic [IDX_W-1:0]             fault_count;

  int n_checks = 0;
  int n_fail   = 0;

  res_t           res_q[$];
  logic [NRU-1:0] clr_q[$];
  int en_any_cyc, en1_cyc, en11_cyc, busy_cyc, zero_viol;
  logic [WS-1:0]  acc [NRU];

  always #5 clk = ~clk;

  ru_multipass_scheduler #(
    .ROWS(ROWS), .COLS(COLS), .INNER(INNER), .WORD_SIZE(WS),
    .NUM_RU(NRU), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .fault_map      (fault_map),
    .top_matrix     (top_matrix),
    .left_matrix    (left_matrix),
    .ru_result      (ru_result),
    .ru_en          (ru_en),
    .ru_clear       (ru_clear),
    .ru_top_inputs  (ru_top_inputs),
    .ru_left_inputs (ru_left_inputs),
    .ru_row_mapping (ru_row_mapping),
    .ru_col_mapping (ru_col_mapping),
    .res_valid      (res_valid),
    .res_row        (res_row),
    .res_col        (res_col),
    .res_data       (res_data),
    .busy           (busy),
    .done           (done),
    .fault_count    (fault_count)
  );

  // RU model: clear or multiply-accumulate per unit.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NRU; i++) begin
      if (rst) acc[i] <= '0;
      else if (ru_clear[i]) acc[i] <= '0;
      else if (ru_en[i]) acc[i] <= acc[i] + ru_top_inputs[i*WS +: WS] * ru_left_inputs[i*WS +: WS];
    end
  end

  always_comb begin
    ru_result = '0;
    for (int i = 0; i < NRU; i++) ru_result[i*WS +: WS] = acc[i];
  end

  // Observation of DUT outputs on the falling edge.
  always @(negedge clk) begin
    if (res_valid) res_q.push_back({res_row, res_col, res_data});
    else if ({res_row, res_col, res_data} != '0) zero_viol++;
    if (ru_clear != '0) clr_q.push_back(ru_clear);
    if (ru_en != '0) en_any_cyc++;
    if (ru_en[1]) en1_cyc++;
    if (ru_en == 2'b11) en11_cyc++;
    if (busy) busy_cyc++;
  end

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic res_t mk_res(input int r, input int c, input int d);
    return {ROW_W'(r), COL_W'(c), WS'(d)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_stats();
    res_q.delete();
    clr_q.delete();
    en_any_cyc = 0; en1_cyc = 0; en11_cyc = 0; busy_cyc = 0; zero_viol = 0;
  endtask

  task automatic start_run(input logic [15:0] map);
    clear_stats();
    fault_map = map;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n = 0;
    while (!done && n < max_cyc) begin
      tick();
      n++;
    end
    check_value({tag, "_done_seen"}, 64'(done), 64'(1));
  endtask

  task automatic wait_en(input string tag);
    int n = 0;
    while (ru_en == '0 && n < 200) begin
      tick();
      n++;
    end
    check_value({tag, "_stream_seen"}, 64'(ru_en != '0), 64'(1));
  endtask

  // Called on the done cycle: count value, then one-cycle pulse and hold.
  task automatic check_end(input string tag, input int exp_fc);
    check_value({tag, "_fault_count"}, 64'(fault_count), 64'(exp_fc));
    check_value({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    tick();
    check_value({tag, "_done_pulse"}, 64'(done), 64'(0));
    check_value({tag, "_fc_hold"}, 64'(fault_count), 64'(exp_fc));
    check_value({tag, "_res_zero"}, 64'(zero_viol), 64'(0));
  endtask

  task automatic check_res(input string tag, input int i, input int r, input int c, input int d);
    if (i < res_q.size()) check_value($sformatf("%s_res%0d", tag, i), 64'(res_q[i]), 64'(mk_res(r, c, d)));
    else check_value($sformatf("%s_res%0d_missing", tag, i), 64'(res_q.size()), 64'(i + 1));
  endtask

  task automatic check_clr(input string tag, input int i, input logic [NRU-1:0] exp);
    if (i < clr_q.size()) check_value($sformatf("%s_clr%0d", tag, i), 64'(clr_q[i]), 64'(exp));
    else check_value($sformatf("%s_clr%0d_missing", tag, i), 64'(clr_q.size()), 64'(i + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; fault_map = '1;
    for (int k = 0; k < INNER; k++)
      for (int c = 0; c < COLS; c++) top_matrix[(k*COLS + c)*WS +: WS] = WS'(c + 1);
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < INNER; k++) left_matrix[(r*INNER + k)*WS +: WS] = WS'(1);
    clear_stats();
    repeat (3) tick();
    check_value("rst_busy", 64'(busy), 64'(0));
    check_value("rst_done", 64'(done), 64'(0));
    check_value("rst_ru_en", 64'(ru_en), 64'(0));
    check_value("rst_res_valid", 64'(res_valid), 64'(0));
    check_value("rst_fault_count", 64'(fault_count), 64'(0));
    rst = 1'b0;
    repeat (2) tick();

    // 1: no faults -> 16 scan cycles, nothing recomputed.
    start_run(16'hFFFF);
    wait_done("t1", 100);
    check_value("t1_en_cycles", 64'(en_any_cyc), 64'(0));
    check_value("t1_res_count", 64'(res_q.size()), 64'(0));
    check_value("t1_busy_cycles", 64'(busy_cyc), 64'(16));
    check_end("t1", 0);

    // 2: PEs (0,1),(1,1) -> one pass of two slots.
    start_run(16'b1111_1111_1101_1101);
    wait_done("t2", 200);
    check_value("t2_res_count", 64'(res_q.size()), 64'(2));
    check_res("t2", 0, 0, 1, 8);
    check_res("t2", 1, 1, 1, 8);
    check_value("t2_en11_cycles", 64'(en11_cyc), 64'(4));
    check_value("t2_en_cycles", 64'(en_any_cyc), 64'(4));
    check_value("t2_busy_cycles", 64'(busy_cyc), 64'(25));
    check_value("t2_passes", 64'(clr_q.size()), 64'(1));
    check_end("t2", 2);

    // 3: five faults -> passes of 2,2,1 slots.
    start_run(16'h7DB6);
    wait_done("t3", 300);
    check_value("t3_res_count", 64'(res_q.size()), 64'(5));
    check_res("t3", 0, 0, 0, 4);
    check_res("t3", 1, 0, 3, 16);
    check_res("t3", 2, 1, 2, 12);
    check_res("t3", 3, 2, 1, 8);
    check_res("t3", 4, 3, 3, 16);
    check_value("t3_passes", 64'(clr_q.size()), 64'(3));
    check_clr("t3", 0, 2'b11);
    check_clr("t3", 1, 2'b11);
    check_clr("t3", 2, 2'b01);
    check_value("t3_en1_cycles", 64'(en1_cyc), 64'(8));
    check_value("t3_busy_cycles", 64'(busy_cyc), 64'(42));
    check_end("t3", 5);

    // 4: PE 10 fails during STREAM -> rescan picks it up, (0,1) not repeated.
    start_run(16'hFFFD);
    wait_en("t4");
    fault_map = 16'hFBFD;
    wait_done("t4", 300);
    check_value("t4_res_count", 64'(res_q.size()), 64'(2));
    check_res("t4", 0, 0, 1, 8);
    check_res("t4", 1, 2, 2, 12);
    check_value("t4_passes", 64'(clr_q.size()), 64'(2));
    check_end("t4", 2);
    fault_map = 16'hFFFF;
    tick();

    // 5a: start re-pulsed while busy is ignored.
    start_run(16'hFFDF);
    wait_en("t5");
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t5", 200);
    check_value("t5_res_count", 64'(res_q.size()), 64'(1));
    check_res("t5", 0, 1, 1, 8);
    check_value("t5_busy_cycles", 64'(busy_cyc), 64'(24));
    check_end("t5", 1);

    // 5b: reset in STREAM clears outputs without waiting for a clock.
    start_run(16'hFFDF);
    wait_en("t5r");
    #1 rst = 1'b1;
    #1;
    check_value("t5r_busy", 64'(busy), 64'(0));
    check_value("t5r_ru_en", 64'(ru_en), 64'(0));
    check_value("t5r_operands", 64'({ru_top_inputs, ru_left_inputs}), 64'(0));
    check_value("t5r_mapping", 64'({ru_row_mapping, ru_col_mapping}), 64'(0));
    check_value("t5r_res", 64'({res_valid, res_row, res_col, res_data}), 64'(0));
    tick();
    rst = 1'b0;
    clear_stats();
    repeat (40) tick();
    check_value("t5r_no_res", 64'(res_q.size()), 64'(0));
    check_value("t5r_no_busy", 64'(busy_cyc), 64'(0));
    check_value("t5r_fault_count", 64'(fault_count), 64'(0));

    // 6: fault heals mid-run -> still recomputed once, no rescan pass.
    start_run(16'hFFDF);
    wait_en("t6");
    fault_map = 16'hFFFF;
    wait_done("t6", 200);
    check_value("t6_res_count", 64'(res_q.size()), 64'(1));
    check_res("t6", 0, 1, 1, 8);
    check_value("t6_passes", 64'(clr_q.size()), 64'(1));
    check_value("t6_busy_cycles", 64'(busy_cyc), 64'(24));
    check_end("t6", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
